// File: rtl/mar_addr_seq.sv
// mar_addr_seq: memory address sequencer for the LC3 datapath.
// Selects adder result or trap vector, registers it into MAR and, in
// indirect modes, fetches a pointer from memory and reloads MAR from MDR.
// A bounded wait counter converts a stalled pointer read into a Fault pulse.
//
// Handshake: Start is a request sampled only while Busy=0 (IDLE); there is
// no back-pressure beyond Busy, and requests seen while Busy=1 are dropped.
// Mem_Req stays high for every FETCH cycle and Mem_Ready completes the read
// on the edge where both are high. Valid is a one-cycle completion pulse.
module mar_addr_seq #(
  parameter int                 ADDR_W   = 16,
  parameter int                 VEC_W    = 8,
  parameter logic [ADDR_W-1:0]  VEC_BASE = '0,
  parameter int                 MAX_WAIT = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] Adder,
  input  logic [ADDR_W-1:0] IR,
  input  logic [ADDR_W-1:0] MDR,
  input  logic [1:0]        Mode,
  input  logic              Start,
  input  logic              Mem_Ready,
  output logic [ADDR_W-1:0] MAR,
  output logic              Mem_Req,
  output logic              Busy,
  output logic              Valid,
  output logic              Fault,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [ADDR_W-1:0]  mar_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               fault_q, fault_d;
  logic [ADDR_W-1:0]  vec_addr;
  logic [ADDR_W-1:0]  first_addr;
  logic               ir_unused;

  // Upper IR bits never feed the vector; bits above VEC_W come only from VEC_BASE.
  assign ir_unused  = ^IR[ADDR_W-1:VEC_W];
  assign vec_addr   = VEC_BASE | {{(ADDR_W-VEC_W){1'b0}}, IR[VEC_W-1:0]};
  assign first_addr = Mode[0] ? vec_addr : Adder;

  // State, MAR, wait counter and latched fault flag; async reset abandons any fetch.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= S_IDLE;
      MAR     <= '0;
      cnt     <= '0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_d;
      MAR     <= mar_d;
      cnt     <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic: accept in IDLE, wait for the pointer in FETCH, report in DONE.
  always_comb begin
    state_d = state;
    mar_d   = MAR;
    cnt_d   = cnt;
    fault_d = fault_q;
    case (state)
      S_IDLE: begin
        fault_d = 1'b0;
        if (Start) begin
          mar_d   = first_addr;
          cnt_d   = '0;
          state_d = Mode[1] ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: begin
        if (Mem_Ready) begin
          // Ready on the last allowed cycle still wins over the timeout.
          mar_d   = MDR;
          fault_d = 1'b0;
          state_d = S_DONE;
        end else if (cnt == CNT_W'(MAX_WAIT - 1)) begin
          // Counter saturates at MAX_WAIT; MAR keeps the pointer address.
          cnt_d   = cnt + CNT_W'(1);
          fault_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs decode registered state only, so they cannot glitch.
  assign Mem_Req   = (state == S_FETCH);
  assign Busy      = (state != S_IDLE);
  assign Valid     = (state == S_DONE);
  assign Fault     = (state == S_DONE) && fault_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_mar_addr_seq.sv
// Directed testbench for mar_addr_seq: default build, a VEC_BASE build and
// a wide-address build, all checked against hand-computed values.
module tb_mar_addr_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- default build ----------------
  logic [15:0] adder = '0, ir = '0, mdr = '0;
  logic [1:0]  mode = '0;
  logic        start = 1'b0, ready = 1'b0;
  logic [15:0] mar;
  logic        mem_req, busy, valid, fault;
  logic [1:0]  st;

  mar_addr_seq dut (
    .CLK(clk), .RESET(rst), .Adder(adder), .IR(ir), .MDR(mdr), .Mode(mode),
    .Start(start), .Mem_Ready(ready), .MAR(mar), .Mem_Req(mem_req),
    .Busy(busy), .Valid(valid), .Fault(fault), .state_dbg(st)
  );

  // ---------------- VEC_BASE build ----------------
  logic [15:0] ir_b = '0;
  logic [1:0]  mode_b = '0;
  logic        start_b = 1'b0;
  logic [15:0] mar_b;
  logic        mem_req_b, busy_b, valid_b, fault_b;
  logic [1:0]  st_b;

  mar_addr_seq #(.VEC_BASE(16'h0400)) dut_b (
    .CLK(clk), .RESET(rst), .Adder(16'h0000), .IR(ir_b), .MDR(16'h0000),
    .Mode(mode_b), .Start(start_b), .Mem_Ready(1'b0), .MAR(mar_b),
    .Mem_Req(mem_req_b), .Busy(busy_b), .Valid(valid_b), .Fault(fault_b),
    .state_dbg(st_b)
  );

  // ---------------- wide build ----------------
  logic [19:0] adder_w = '0, ir_w = '0, mdr_w = '0;
  logic [1:0]  mode_w = '0;
  logic        start_w = 1'b0, ready_w = 1'b0;
  logic [19:0] mar_w;
  logic        mem_req_w, busy_w, valid_w, fault_w;
  logic [1:0]  st_w;

  mar_addr_seq #(.ADDR_W(20), .VEC_W(10)) dut_w (
    .CLK(clk), .RESET(rst), .Adder(adder_w), .IR(ir_w), .MDR(mdr_w),
    .Mode(mode_w), .Start(start_w), .Mem_Ready(ready_w), .MAR(mar_w),
    .Mem_Req(mem_req_w), .Busy(busy_w), .Valid(valid_w), .Fault(fault_w),
    .state_dbg(st_w)
  );

  // ---------------- checking ----------------
  int n_pass  = 0;
  int n_check = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_check++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;

    tick();
    check("rst_mar", 32'(mar), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // Enter FETCH, then reset asynchronously mid-fetch.
    adder = 16'h4000; mode = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    check("pre_rst_memreq", 32'(mem_req), 32'h1);
    check("pre_rst_mar", 32'(mar), 32'h4000);
    rst = 1'b1;
    #1;
    check("async_rst_mar", 32'(mar), 32'h0);
    check("async_rst_flags", {28'h0, mem_req, busy, valid, fault}, 32'h0);
    check("async_rst_state", 32'(st), 32'h0);
    tick();
    rst = 1'b0;

    // Direct adder right after reset.
    adder = 16'h3010; mode = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    check("dir_adder_mar", 32'(mar), 32'h3010);
    check("dir_adder_valid", {28'h0, mem_req, busy, valid, fault}, 32'b0110);
    tick();
    check("dir_adder_idle", {28'h0, mem_req, busy, valid, fault}, 32'h0);
    check("dir_adder_hold", 32'(mar), 32'h3010);

    // Direct vector with Start held high: second request only at edge t+2.
    ir = 16'hF025; mode = 2'b01; start = 1'b1;
    tick();
    check("dir_vec_mar", 32'(mar), 32'h0025);
    check("dir_vec_valid", 32'(valid), 32'h1);
    ir = 16'hF031;
    tick();
    check("b2b_idle_gap", 32'(busy), 32'h0);
    check("b2b_gap_mar", 32'(mar), 32'h0025);
    tick();
    start = 1'b0;
    check("b2b_second_mar", 32'(mar), 32'h0031);
    check("b2b_second_valid", 32'(valid), 32'h1);
    tick();

    // Indirect success: Mem_Ready on the 3rd FETCH cycle.
    adder = 16'h4000; mode = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    check("ind_f1", {28'h0, mem_req, busy, valid, fault}, 32'b1100);
    check("ind_f1_mar", 32'(mar), 32'h4000);
    tick();
    check("ind_f2", 32'(mem_req), 32'h1);
    tick();
    check("ind_f3", 32'(mem_req), 32'h1);
    check("ind_f3_mar", 32'(mar), 32'h4000);
    ready = 1'b1; mdr = 16'h5A5A;
    tick();
    ready = 1'b0;
    check("ind_done_mar", 32'(mar), 32'h5A5A);
    check("ind_done_flags", {28'h0, mem_req, busy, valid, fault}, 32'b0110);
    tick();
    check("ind_idle", {28'h0, mem_req, busy, valid, fault}, 32'h0);

    // Timeout: count Mem_Req cycles with a bounded loop.
    ir = 16'h0020; mode = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && mem_req; i++) begin
      n++;
      tick();
    end
    check("to_memreq_cycles", 32'(n), 32'd15);
    check("to_flags", {28'h0, mem_req, busy, valid, fault}, 32'b0111);
    check("to_mar", 32'(mar), 32'h0020);
    tick();
    check("to_idle", {28'h0, mem_req, busy, valid, fault}, 32'h0);

    // Mem_Ready on the 15th FETCH cycle is a success.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check("last_f15_memreq", 32'(mem_req), 32'h1);
    ready = 1'b1; mdr = 16'h1234;
    tick();
    ready = 1'b0;
    check("last_flags", {28'h0, mem_req, busy, valid, fault}, 32'b0110);
    check("last_mar", 32'(mar), 32'h1234);
    tick();

    // Ignored inputs during FETCH, DONE and IDLE.
    adder = 16'h1111; mode = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    adder = 16'h2222; mode = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_fetch_mar", 32'(mar), 32'h1111);
    check("ign_fetch_state", 32'(st), 32'h1);
    ready = 1'b1; mdr = 16'h3333;
    tick();
    ready = 1'b0;
    check("ign_done_mar", 32'(mar), 32'h3333);
    adder = 16'h4444; start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_done_start", {28'h0, mem_req, busy, valid, fault}, 32'h0);
    check("ign_done_mar2", 32'(mar), 32'h3333);
    ready = 1'b1; mdr = 16'h7777;
    tick();
    ready = 1'b0;
    check("ign_idle_ready", {28'h0, mem_req, busy, valid, fault}, 32'h0);
    check("ign_idle_mar", 32'(mar), 32'h3333);

    // VEC_BASE build.
    ir_b = 16'hF025; mode_b = 2'b01; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("base_vec_mar", 32'(mar_b), 32'h0425);
    check("base_vec_valid", 32'(valid_b), 32'h1);
    tick();

    // Wide build: vector then indirect.
    ir_w = 20'hFFFFF; mode_w = 2'b01; start_w = 1'b1;
    tick();
    start_w = 1'b0;
    check("wide_vec_mar", 32'(mar_w), 32'h003FF);
    check("wide_vec_valid", 32'(valid_w), 32'h1);
    tick();
    adder_w = 20'h12345; mode_w = 2'b10; start_w = 1'b1;
    tick();
    start_w = 1'b0;
    check("wide_ind_ptr", 32'(mar_w), 32'h12345);
    ready_w = 1'b1; mdr_w = 20'hABCDE;
    tick();
    ready_w = 1'b0;
    check("wide_ind_mar", 32'(mar_w), 32'hABCDE);
    check("wide_ind_flags", {28'h0, mem_req_w, busy_w, valid_w, fault_w}, 32'b0110);

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule

// File: doc/mar_addr_seq.md
# mar_addr_seq

Parametrised successor to the single-cycle MAR multiplexer: selects the memory address source (adder result or zero-extended trap vector), registers it into MAR, and adds a sequenced indirect mode that fetches a pointer from memory and reloads MAR from MDR. It sits between the address adder/IR and the MAR/memory interface of the LC3 datapath. A bounded wait counter turns a memory stall into a reported fault instead of a hang.

## Interface
- ADDR_W, 16, address/data width of Adder, IR, MDR, MAR
- VEC_W, 8, number of IR low bits used as trap vector (1 ≤ VEC_W < ADDR_W)
- VEC_BASE, 0, ADDR_W-bit constant ORed onto the zero-extended vector
- MAX_WAIT, 15, maximum cycles spent in FETCH waiting for Mem_Ready (≥1)
- CLK  in  1  single clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- Adder  in  ADDR_W  address from the address adder
- IR  in  ADDR_W  instruction register; only IR[VEC_W-1:0] used
- MDR  in  ADDR_W  memory data register (pointer value in indirect mode)
- Mode  in  2  00 direct-adder, 01 direct-vector, 10 indirect-adder, 11 indirect-vector
- Start  in  1  request; sampled only in IDLE
- Mem_Ready  in  1  memory read complete, MDR valid this cycle
- MAR  out  ADDR_W  registered memory address
- Mem_Req  out  1  pointer-read request, high throughout FETCH
- Busy  out  1  high whenever state ≠ IDLE
- Valid  out  1  one-cycle pulse: MAR holds final address
- Fault  out  1  one-cycle pulse coincident with Valid when the pointer fetch timed out

## Operation
- Vector address: VEC_BASE | {zeros, IR[VEC_W-1:0]}; bits above VEC_W come only from VEC_BASE.
- First address: Mode[0]=0 → Adder, Mode[0]=1 → vector address.
- States: IDLE, FETCH, DONE.
- IDLE: on Start=1, MAR ← first address; Mode[1]=0 → DONE, Mode[1]=1 → FETCH with wait counter cleared. Start=0 → MAR holds.
- FETCH: Mem_Req=1. When Mem_Ready=1 at an edge, MAR ← MDR and go to DONE, Fault=0. If counter reaches MAX_WAIT without Mem_Ready, go to DONE with MAR unchanged (pointer address) and Fault latched for DONE. Otherwise counter increments.
- DONE: Valid=1 (Fault as latched) for exactly one cycle → IDLE.
- Start outside IDLE is ignored (not queued). Mem_Ready outside FETCH is ignored. Mode, Adder, IR are sampled only at the accepting edge; later changes have no effect.
- MAR changes only on the accepting edge or the Mem_Ready edge in FETCH; it holds in all other cycles, including across IDLE.
- Counter width: clog2(MAX_WAIT+1) bits, no wrap (stops at MAX_WAIT).

## Timing
- Reset (async, any state): MAR=0, state=IDLE, counter=0, Mem_Req=0, Busy=0, Valid=0, Fault=0. This applies immediately, mid-FETCH included; a pending fetch is abandoned.
- First Start accepted on the first rising edge after RESET deasserts.
- Direct modes: Start sampled at edge t → MAR valid and Valid=1 in cycle t+1 → IDLE after edge t+1. Back-to-back Start accepted no sooner than edge t+2.
- Indirect modes: edge t accept → FETCH in cycle t+1 (Mem_Req=1, MAR=pointer address). Mem_Ready high in the k-th FETCH cycle (k ≥ 1) → MAR=MDR and Valid in cycle t+1+k.
- Timeout: no Mem_Ready in MAX_WAIT FETCH cycles → Valid=Fault=1 in cycle t+1+MAX_WAIT+... precisely the cycle after the MAX_WAIT-th FETCH cycle.
- Mem_Ready on the MAX_WAIT-th FETCH cycle counts as success, not fault.
- Outputs Mem_Req, Busy, Valid, and Fault are decoded from registered state only and are glitch-free.

## Test plan
- Reset: assert RESET mid-FETCH → all outputs 0, MAR=0x0000 immediately. Deassert, then Start Mode=00 with Adder=0x3010 → MAR=0x3010 and Valid one cycle later.
- Direct vector: IR=0xF025, Mode=01, defaults → MAR=0x0025 and Valid=1 one cycle after Start. Rebuild with VEC_BASE=0x0400 → MAR=0x0425.
- Indirect success: Mode=10, Adder=0x4000. Mem_Ready on the 3rd FETCH cycle with MDR=0x5A5A → Mem_Req high 3 cycles, MAR=0x4000 during FETCH, then MAR=0x5A5A with Valid=1 and Fault=0.
- Timeout: Mode=11, IR=0x0020, Mem_Ready held low → exactly 15 Mem_Req cycles, then Valid=Fault=1 and MAR=0x0020. Repeat with Mem_Ready on the 15th cycle → Fault=0.
- Ignored inputs: pulse Start and change Adder during FETCH and DONE, and pulse Mem_Ready in IDLE → MAR, state, and Valid count unaffected.
- Width sweep: ADDR_W=20, VEC_W=10, IR=0xFFFFF → vector MAR=0x003FF. Indirect MDR=0xABCDE → MAR=0xABCDE.
